// File: rtl/matmult_tile_engine_if.sv
// Operand-read, result-write and job-control signals of the tile engine.
// master is the engine's view; slave is the controller/buffer side.
interface matmult_tile_engine_if #(
   parameter int LANES      = 16,
   parameter int IN_W       = 8,
   parameter int ACC_W      = 32,
   parameter int ADDR_W     = 8,
   parameter int OUT_ADDR_W = 8,
   parameter int PASS_W     = 4
);
   logic                    Start;
   logic [OUT_ADDR_W-1:0]   Num_out;
   logic [PASS_W-1:0]       Num_pass;
   logic [LANES*IN_W-1:0]   A;
   logic [LANES*IN_W-1:0]   B;
   logic                    Rd_en;
   logic [ADDR_W-1:0]       Rd_A_addr;
   logic [ADDR_W-1:0]       Rd_B_addr;
   logic                    Wr_en;
   logic [OUT_ADDR_W-1:0]   Wr_addr;
   logic [ACC_W-1:0]        C;
   logic                    Busy;
   logic                    Done;

   modport master (
      input  Start, Num_out, Num_pass, A, B,
      output Rd_en, Rd_A_addr, Rd_B_addr, Wr_en, Wr_addr, C, Busy, Done
   );

   modport slave (
      output Start, Num_out, Num_pass, A, B,
      input  Rd_en, Rd_A_addr, Rd_B_addr, Wr_en, Wr_addr, C, Busy, Done
   );
endinterface

// File: rtl/matmult_tile_engine.sv
// Pipelined dot-product engine: LANES-wide multiply, registered adder tree,
// and multi-pass accumulation into one result per Num_pass chunks.
module matmult_tile_engine #(
   parameter int LANES      = 16,
   parameter int IN_W       = 8,
   parameter int ACC_W      = 32,
   parameter int ADDR_W     = 8,
   parameter int OUT_ADDR_W = 8,
   parameter int PASS_W     = 4
) (
   input logic Clk,
   input logic Rst,
   matmult_tile_engine_if.master bus
);
   localparam int L     = $clog2(LANES);
   localparam int DEPTH = L + 2;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic                  valid;
      logic                  first;
      logic                  last;
      logic [OUT_ADDR_W-1:0] idx;
   } tag_t;

   state_t                  state_q, state_d;
   logic [OUT_ADDR_W-1:0]   numOut_q, numOut_d, outIdx_q, outIdx_d;
   logic [PASS_W-1:0]       numPass_q, numPass_d, passCnt_q, passCnt_d;
   logic                    rdEn_q, rdEn_d;
   logic [ADDR_W-1:0]       rdAddr_q, rdAddr_d;
   logic                    busy_q, busy_d, done_q, done_d;
   logic                    lastPass, lastRead, pipeBusy;
   tag_t                    rdTag, treeTag;
   tag_t                    tagPipe_q [DEPTH];
   logic signed [ACC_W-1:0] prod [LANES];
   logic signed [ACC_W-1:0] node [2*LANES-1];
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    wrEn_q, wrEn_d;
   logic [OUT_ADDR_W-1:0]   wrAddr_q, wrAddr_d;

   // Tag of the read currently on the bus; it trails the data through the pipe.
   always_comb begin
      lastPass    = (passCnt_q == numPass_q - PASS_W'(1));
      lastRead    = lastPass && (outIdx_q == numOut_q - OUT_ADDR_W'(1));
      rdTag.valid = rdEn_q;
      rdTag.first = (passCnt_q == '0);
      rdTag.last  = lastPass;
      rdTag.idx   = outIdx_q;
      pipeBusy    = 1'b0;
      for (int s = 0; s < DEPTH; s++) pipeBusy |= tagPipe_q[s].valid;
   end

   always_comb begin
      state_d   = state_q;
      numOut_d  = numOut_q;
      numPass_d = numPass_q;
      outIdx_d  = outIdx_q;
      passCnt_d = passCnt_q;
      rdEn_d    = 1'b0;
      rdAddr_d  = '0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (bus.Start) begin
               numOut_d  = bus.Num_out;
               numPass_d = bus.Num_pass;
               outIdx_d  = '0;
               passCnt_d = '0;
               busy_d    = 1'b1;
               if (bus.Num_out == '0 || bus.Num_pass == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RUN;
                  rdEn_d  = 1'b1;
               end
            end
         end
         RUN: begin
            if (lastRead) begin
               state_d = DRAIN;
            end else begin
               rdEn_d   = 1'b1;
               rdAddr_d = rdAddr_q + ADDR_W'(1);
               if (lastPass) begin
                  passCnt_d = '0;
                  outIdx_d  = outIdx_q + OUT_ADDR_W'(1);
               end else begin
                  passCnt_d = passCnt_q + PASS_W'(1);
               end
            end
         end
         DRAIN: begin
            // The final write is the only one issued with nothing left in flight.
            if (wrEn_q && !pipeBusy) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         prod[i] = ACC_W'($signed(bus.A[i*IN_W +: IN_W])) *
                   ACC_W'($signed(bus.B[i*IN_W +: IN_W]));
      end
   end

   always_comb begin
      treeTag  = tagPipe_q[DEPTH-1];
      acc_d    = acc_q;
      wrEn_d   = 1'b0;
      wrAddr_d = '0;
      if (treeTag.valid) begin
         acc_d = treeTag.first ? node[0] : (acc_q + node[0]);
         if (treeTag.last) begin
            wrEn_d   = 1'b1;
            wrAddr_d = treeTag.idx;
         end
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q   <= IDLE;
         numOut_q  <= '0;
         numPass_q <= '0;
         outIdx_q  <= '0;
         passCnt_q <= '0;
         rdEn_q    <= 1'b0;
         rdAddr_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         acc_q     <= '0;
         wrEn_q    <= 1'b0;
         wrAddr_q  <= '0;
         for (int s = 0; s < DEPTH; s++) tagPipe_q[s] <= '0;
      end else begin
         state_q   <= state_d;
         numOut_q  <= numOut_d;
         numPass_q <= numPass_d;
         outIdx_q  <= outIdx_d;
         passCnt_q <= passCnt_d;
         rdEn_q    <= rdEn_d;
         rdAddr_q  <= rdAddr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         acc_q     <= acc_d;
         wrEn_q    <= wrEn_d;
         wrAddr_q  <= wrAddr_d;
         tagPipe_q[0] <= rdTag;
         for (int s = 1; s < DEPTH; s++) tagPipe_q[s] <= tagPipe_q[s-1];
      end
   end

   // Heap-ordered tree: leaves hold the products, node 0 is the full sum L cycles later.
   always_ff @(posedge Clk) begin
      for (int i = 0; i < LANES; i++) node[LANES-1+i] <= prod[i];
      for (int n = 0; n < LANES-1; n++) node[n] <= node[2*n+1] + node[2*n+2];
   end

   assign bus.Rd_en     = rdEn_q;
   assign bus.Rd_A_addr = rdAddr_q;
   assign bus.Rd_B_addr = rdAddr_q;
   assign bus.Wr_en     = wrEn_q;
   assign bus.Wr_addr   = wrAddr_q;
   assign bus.C         = acc_q;
   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;
endmodule

// File: tb/tb_matmult_tile_engine.sv
// Directed bench for matmult_tile_engine with a write scoreboard and a model
// of the operand buffers; a second instance covers the 16-bit accumulator.
module tb_matmult_tile_engine;
   localparam int LANES      = 16;
   localparam int IN_W       = 8;
   localparam int OUT_ADDR_W = 8;
   localparam int PASS_W     = 4;
   localparam int LAT        = 7;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  addr;
      int          cyc;
   } exp_t;

   logic Clk = 1'b0;
   logic Rst;
   int   cyc = 0;
   int   passCount = 0;
   int   failCount = 0;
   int   memMode = 0;
   int   r0 = 0;
   int   r16 = 0;
   int   rdSeen = 0;
   int   wrSeen = 0;
   bit   got;
   exp_t sbQ [$];
   exp_t wrE;

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   matmult_tile_engine_if #(.ACC_W(32)) bus ();
   matmult_tile_engine_if #(.ACC_W(16)) bus16 ();

   matmult_tile_engine #(.ACC_W(32)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
   matmult_tile_engine #(.ACC_W(16)) dut16 (.Clk(Clk), .Rst(Rst), .bus(bus16));

   function automatic int laneA(input int mode, input int addr);
      case (mode)
         0:       return addr + 1;
         1:       return 1;
         2:       return -128;
         default: return 127;
      endcase
   endfunction

   function automatic int laneB(input int mode, input int addr);
      case (mode)
         0:       return 2;
         1:       return -1;
         2:       return -128;
         default: return 127;
      endcase
   endfunction

   function automatic logic [LANES*IN_W-1:0] packLanes(input int v);
      logic [LANES*IN_W-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = IN_W'(v);
      return r;
   endfunction

   // Operand buffers with one cycle of read latency
   always @(posedge Clk) begin
      bus.A   <= packLanes(laneA(memMode, int'(bus.Rd_A_addr)));
      bus.B   <= packLanes(laneB(memMode, int'(bus.Rd_B_addr)));
      bus16.A <= packLanes(127);
      bus16.B <= packLanes(127);
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (Rst === 1'b0 && bus.Wr_en === 1'b1) begin
         wrSeen++;
         checkOutput("wr_expected", sbQ.size() != 0, 1'b1);
         if (sbQ.size() != 0) begin
            wrE = sbQ.pop_front();
            checkOutput("wr_data", bus.C, wrE.data);
            checkOutput("wr_addr", bus.Wr_addr, wrE.addr);
            checkOutput("wr_cycle", cyc, wrE.cyc);
         end
      end
   end

   always @(negedge Clk) begin
      if (Rst === 1'b0) begin
         if (bus.Rd_en === 1'b1) begin
            checkOutput("rd_addr_a", bus.Rd_A_addr, 8'(rdSeen));
            checkOutput("rd_addr_b", bus.Rd_B_addr, 8'(rdSeen));
            checkOutput("rd_cycle", cyc, r0 + rdSeen);
            rdSeen++;
         end else begin
            checkOutput("rd_addr_idle", {bus.Rd_A_addr, bus.Rd_B_addr}, 16'h0);
         end
      end
   end

   task automatic applyStimulus(input int nOut, input int nPass, input int mode);
      int   sum;
      exp_t e;
      @(posedge Clk);
      #1;
      memMode      = mode;
      bus.Start    = 1'b1;
      bus.Num_out  = OUT_ADDR_W'(nOut);
      bus.Num_pass = PASS_W'(nPass);
      r0     = cyc + 1;
      rdSeen = 0;
      wrSeen = 0;
      for (int o = 0; o < nOut; o++) begin
         sum = 0;
         for (int p = 0; p < nPass; p++) begin
            sum += LANES * laneA(mode, o*nPass + p) * laneB(mode, o*nPass + p);
         end
         e.data = 32'(sum);
         e.addr = 8'(o);
         e.cyc  = r0 + (o+1)*nPass - 1 + LAT;
         sbQ.push_back(e);
      end
      @(posedge Clk);
      #1;
      bus.Start = 1'b0;
   endtask

   task automatic waitDone(input int expCyc, input int expReads);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge Clk);
         if (bus.Done === 1'b1) seen = 1'b1;
      end
      checkOutput("done_seen", seen, 1'b1);
      if (seen) begin
         checkOutput("done_cycle", cyc, expCyc);
         checkOutput("busy_at_done", bus.Busy, 1'b1);
      end
      checkOutput("sb_empty", sbQ.size(), 0);
      checkOutput("rd_count", rdSeen, expReads);
      @(negedge Clk);
      checkOutput("busy_after_done", bus.Busy, 1'b0);
      checkOutput("done_pulse", bus.Done, 1'b0);
   endtask

   initial begin
      Rst = 1'b1;
      bus.Start = 1'b0;   bus.Num_out = '0;   bus.Num_pass = '0;
      bus16.Start = 1'b0; bus16.Num_out = '0; bus16.Num_pass = '0;
      repeat (2) @(posedge Clk);
      #1;
      checkOutput("rst_rd_en", bus.Rd_en, 1'b0);
      checkOutput("rst_rd_addr", {bus.Rd_A_addr, bus.Rd_B_addr}, 16'h0);
      checkOutput("rst_wr_en", bus.Wr_en, 1'b0);
      checkOutput("rst_wr_addr", bus.Wr_addr, 8'h0);
      checkOutput("rst_c", bus.C, 32'h0);
      checkOutput("rst_busy", bus.Busy, 1'b0);
      checkOutput("rst_done", bus.Done, 1'b0);
      Rst = 1'b0;

      $display("[TB] 4x1 job, A=addr+1 B=2");
      applyStimulus(4, 1, 0);
      checkOutput("busy_r0", bus.Busy, 1'b1);
      waitDone(r0 + 4 + LAT, 4);

      $display("[TB] 2x3 job, A=1 B=-1");
      applyStimulus(2, 3, 1);
      waitDone(r0 + 6 + LAT, 6);

      $display("[TB] 1x1 job, A=B=-128");
      applyStimulus(1, 1, 2);
      waitDone(r0 + 1 + LAT, 1);

      $display("[TB] 16-bit accumulator wrap");
      @(posedge Clk);
      #1;
      bus16.Start = 1'b1; bus16.Num_out = 8'd1; bus16.Num_pass = 4'd2;
      r16 = cyc + 1;
      @(posedge Clk);
      #1;
      bus16.Start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge Clk);
         if (bus16.Wr_en === 1'b1) got = 1'b1;
      end
      checkOutput("acc16_wr_seen", got, 1'b1);
      if (got) begin
         checkOutput("acc16_c", bus16.C, 16'hE020);
         checkOutput("acc16_addr", bus16.Wr_addr, 8'h0);
         checkOutput("acc16_cycle", cyc, r16 + 8);
      end
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge Clk);
         if (bus16.Done === 1'b1) got = 1'b1;
      end
      checkOutput("acc16_done_seen", got, 1'b1);
      if (got) checkOutput("acc16_done_cycle", cyc, r16 + 9);

      $display("[TB] zero-length job");
      applyStimulus(0, 1, 0);
      waitDone(r0, 0);

      $display("[TB] Start pulsed during RUN");
      applyStimulus(4, 1, 0);
      @(posedge Clk);
      #1;
      bus.Start = 1'b1; bus.Num_out = 8'd7;
      @(posedge Clk);
      #1;
      bus.Start = 1'b0;
      waitDone(r0 + 4 + LAT, 4);
      repeat (12) @(negedge Clk);
      checkOutput("ignored_start_wr_count", wrSeen, 4);

      $display("[TB] reset in the middle of a job");
      applyStimulus(4, 1, 0);
      repeat (3) @(posedge Clk);
      #1;
      Rst = 1'b1;
      #1;
      checkOutput("midrst_rd_en", bus.Rd_en, 1'b0);
      checkOutput("midrst_rd_addr", {bus.Rd_A_addr, bus.Rd_B_addr}, 16'h0);
      checkOutput("midrst_wr_en", bus.Wr_en, 1'b0);
      checkOutput("midrst_wr_addr", bus.Wr_addr, 8'h0);
      checkOutput("midrst_c", bus.C, 32'h0);
      checkOutput("midrst_busy", bus.Busy, 1'b0);
      checkOutput("midrst_done", bus.Done, 1'b0);
      sbQ.delete();
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      repeat (15) @(negedge Clk);
      checkOutput("midrst_no_writes", wrSeen, 0);
      checkOutput("midrst_reads", rdSeen, 3);
      applyStimulus(4, 1, 0);
      waitDone(r0 + 4 + LAT, 4);

      $display("%0d/%0d checks passed", passCount, passCount + failCount);
      $finish;
   end
endmodule
